// File: rtl/seg_accum_display.sv
// Registered adder/accumulator with overflow tracking, driving a scanned
// active-low hexadecimal seven-segment display (WIDTH/4 nibbles plus a carry digit).
module seg_accum_display #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned LZB      = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [WIDTH-1:0]        i_a,
    input  logic [WIDTH-1:0]        i_b,
    input  logic                    i_cin,
    input  logic                    i_mode,
    input  logic                    i_go,
    input  logic                    i_clear,
    output logic [WIDTH-1:0]        o_sum,
    output logic                    o_cout,
    output logic                    o_ovf,
    output logic                    o_valid,
    output logic [6:0]              o_segments,
    output logic [WIDTH/4:0]        o_digit_en
);

    localparam int unsigned NIB    = WIDTH / 4;
    localparam int unsigned DIGITS = NIB + 1;
    localparam int unsigned IW     = $clog2(DIGITS);
    localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_valid;
    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [6:0]        r_segments;
    logic [DIGITS-1:0] r_digit_en;

    logic [WIDTH-1:0]  w_op_a;
    logic [WIDTH-1:0]  w_op_b;
    logic [WIDTH:0]    w_add;
    logic              w_wrap;
    logic [IW-1:0]     w_idx_nxt;
    logic [NIB-1:0]    w_upper_zero;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [6:0]        w_glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Accumulate mode replaces the B operand with the running sum.
    assign w_op_a = i_mode ? r_sum : i_a;
    assign w_op_b = i_mode ? i_a : i_b;
    assign w_add  = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, i_cin};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_go) begin
            r_sum   <= w_add[WIDTH-1:0];
            r_cout  <= w_add[WIDTH];
            r_ovf   <= r_ovf | (i_mode & w_add[WIDTH]);
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign w_wrap    = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

    // w_upper_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NIB-1] = (r_sum[WIDTH-1 -: 4] == 4'h0);
        for (int k = NIB - 2; k >= 0; k--) begin
            w_upper_zero[k] = w_upper_zero[k+1] & (r_sum[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        w_nib   = '0;
        w_blank = 1'b0;
        if (w_idx_nxt == IW'(DIGITS - 1)) begin
            w_nib   = {3'b000, r_cout};
            w_blank = (LZB != 0) && !r_cout;
        end else begin
            for (int k = 0; k < NIB; k++) begin
                if (w_idx_nxt == IW'(k)) begin
                    w_nib   = r_sum[4*k +: 4];
                    w_blank = (LZB != 0) && (k != 0) && w_upper_zero[k];
                end
            end
        end
        w_glyph = w_blank ? 7'b1111111 : hex_glyph(w_nib);
    end

    // Select and glyph load on the same edge so they never disagree.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_digit_en <= ~DIGITS'(1);
            r_segments <= 7'b1000000;
        end else if (w_wrap) begin
            r_presc    <= '0;
            r_idx      <= w_idx_nxt;
            r_digit_en <= ~(DIGITS'(1) << w_idx_nxt);
            r_segments <= w_glyph;
        end else begin
            r_presc    <= r_presc + 1'b1;
        end
    end

    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_ovf      = r_ovf;
    assign o_valid    = r_valid;
    assign o_segments = r_segments;
    assign o_digit_en = r_digit_en;

endmodule

// File: tb/tb_seg_accum_display.sv
// Directed-vector bench for seg_accum_display: one LZB=0 and one LZB=1 instance
// share all inputs so both scan in lockstep.
module tb_seg_accum_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GB = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset, cin, mode, go, clear;
    logic [7:0] a, b;
    logic [7:0] sum0, sum1;
    logic       cout0, cout1, ovf0, ovf1, valid0, valid1;
    logic [6:0] seg0, seg1;
    logic [2:0] en0, en1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg_accum_display #(.WIDTH(8), .SCAN_DIV(4), .LZB(0)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_a(a), .i_b(b), .i_cin(cin), .i_mode(mode),
        .i_go(go), .i_clear(clear), .o_sum(sum0), .o_cout(cout0), .o_ovf(ovf0),
        .o_valid(valid0), .o_segments(seg0), .o_digit_en(en0)
    );

    seg_accum_display #(.WIDTH(8), .SCAN_DIV(4), .LZB(1)) u_dut_lzb (
        .i_clk(clk), .i_reset(reset), .i_a(a), .i_b(b), .i_cin(cin), .i_mode(mode),
        .i_go(go), .i_clear(clear), .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1),
        .o_valid(valid1), .o_segments(seg1), .o_digit_en(en1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sync to the first cycle of digit 0, then check all three digits for 4 cycles each.
    task automatic check_scan(input bit lzb, input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2);
        logic [2:0] prev;
        logic [2:0] cur;
        logic [6:0] exp_g [3];
        logic [2:0] exp_en [3];
        bit found;
        exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2;
        exp_en[0] = 3'b110; exp_en[1] = 3'b101; exp_en[2] = 3'b011;
        found = 1'b0;
        prev = lzb ? en1 : en0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            cur = lzb ? en1 : en0;
            if (prev != 3'b110 && cur == 3'b110) found = 1'b1;
            prev = cur;
        end
        check_eq("scan_sync", 32'(found), 32'd1);
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d != 0 || c != 0) step();
                check_eq($sformatf("scan_en_d%0d_c%0d", d, c),
                         32'(lzb ? en1 : en0), 32'(exp_en[d]));
                check_eq($sformatf("scan_seg_d%0d_c%0d", d, c),
                         32'(lzb ? seg1 : seg0), 32'(exp_g[d]));
            end
        end
    endtask

    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                         input logic vmode);
        a = va; b = vb; cin = vcin; mode = vmode; go = 1'b1;
        step();
        go = 1'b0;
    endtask

    initial begin
        reset = 1'b1; go = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0; mode = 1'b0; clear = 1'b0;
        step();
        step();
        check_eq("rst_sum", 32'(sum0), 32'h00);
        check_eq("rst_cout", 32'(cout0), 32'd0);
        check_eq("rst_ovf", 32'(ovf0), 32'd0);
        check_eq("rst_valid", 32'(valid0), 32'd0);
        check_eq("rst_en", 32'(en0), 32'b110);
        check_eq("rst_seg", 32'(seg0), 32'(G0));
        reset = 1'b0; go = 1'b0;

        // Load 3C + 05 + 1 = 42
        do_op(8'h3C, 8'h05, 1'b1, 1'b0);
        check_eq("load_sum", 32'(sum0), 32'h42);
        check_eq("load_cout", 32'(cout0), 32'd0);
        check_eq("load_valid", 32'(valid0), 32'd1);
        step();
        check_eq("load_valid_drop", 32'(valid0), 32'd0);
        check_scan(1'b0, G2, G4, G0);

        // Operand changes without go leave state untouched
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        step(); step();
        check_eq("idle_sum", 32'(sum0), 32'h42);
        check_eq("idle_valid", 32'(valid0), 32'd0);

        // F0 + 20 wraps to 10 with carry
        do_op(8'hF0, 8'h20, 1'b0, 1'b0);
        check_eq("wrap_sum", 32'(sum0), 32'h10);
        check_eq("wrap_cout", 32'(cout0), 32'd1);
        check_eq("wrap_ovf", 32'(ovf0), 32'd0);
        check_scan(1'b0, G0, G1, G1);

        // Accumulate 80 three times after clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_sum", 32'(sum0), 32'h00);
        check_eq("clr_cout", 32'(cout0), 32'd0);
        a = 8'h80; b = 8'h7F; cin = 1'b0; mode = 1'b1; go = 1'b1;
        step();
        check_eq("acc1_sum", 32'(sum0), 32'h80);
        check_eq("acc1_ovf", 32'(ovf0), 32'd0);
        check_eq("acc1_valid", 32'(valid0), 32'd1);
        step();
        check_eq("acc2_sum", 32'(sum0), 32'h00);
        check_eq("acc2_cout", 32'(cout0), 32'd1);
        check_eq("acc2_ovf", 32'(ovf0), 32'd1);
        step();
        check_eq("acc3_sum", 32'(sum0), 32'h80);
        check_eq("acc3_cout", 32'(cout0), 32'd0);
        check_eq("acc3_ovf", 32'(ovf0), 32'd1);
        check_eq("acc3_valid", 32'(valid0), 32'd1);
        go = 1'b0;
        step();
        check_eq("acc_valid_drop", 32'(valid0), 32'd0);

        // Mode-0 op with carry-free result must not clear sticky ovf
        do_op(8'h01, 8'h01, 1'b0, 1'b0);
        check_eq("m0_sum", 32'(sum0), 32'h02);
        check_eq("m0_ovf_keep", 32'(ovf0), 32'd1);

        // clear beats go
        a = 8'h80; mode = 1'b1; clear = 1'b1; go = 1'b1;
        step();
        clear = 1'b0; go = 1'b0;
        check_eq("prio_sum", 32'(sum0), 32'h00);
        check_eq("prio_ovf", 32'(ovf0), 32'd0);
        check_eq("prio_valid", 32'(valid0), 32'd0);

        // Leading-zero blanking
        do_op(8'h05, 8'h00, 1'b0, 1'b0);
        check_eq("lzb_sum", 32'(sum1), 32'h05);
        check_scan(1'b1, G5, GB, GB);
        do_op(8'h50, 8'h00, 1'b0, 1'b0);
        check_scan(1'b1, G0, G5, GB);
        check_scan(1'b0, G0, G5, G0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_accum_display.md
Name: seg_accum_display

Overview:
Parametrised registered adder/accumulator with a multiplexed hexadecimal seven-segment display.
- A and B are added with carry-in, in either single-shot or running-accumulate mode.
- The WIDTH-bit result and carry are displayed on WIDTH/4+1 time-multiplexed digits, active-low: WIDTH/4 hex digits plus one carry digit.
- Sits between board switches/buttons and the shared segment/anode pins.
- Generalises the combinational 4-bit sum/carry display to any nibble-multiple width, with registered results, accumulation, overflow tracking and scanning.

Parameters:
WIDTH, 8, operand/result width; must be a multiple of 4 and at least 4.
SCAN_DIV, 50000, clock cycles each digit is held during scanning; must be at least 1.
LZB, 0, 1 = leading-zero blanking enabled; 0 = all digits always shown.
DIGITS, WIDTH/4+1, derived parameter (not overridable); count of hex digits plus one carry digit.

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
A  in  WIDTH  operand A
B  in  WIDTH  operand B; ignored when mode=1
cin  in  1  carry in
mode  in  1  0 = load: sum<=A+B+cin; 1 = accumulate: sum<=sum+A+cin
go  in  1  execute strobe, sampled every cycle
clear  in  1  zeroes sum, cout, ovf
sum  out  WIDTH  registered result
cout  out  1  registered carry of the most recent operation
ovf  out  1  sticky flag, set by any carry out while mode=1
valid  out  1  one-cycle pulse, one cycle after an accepted go
segments  out  7  active-low; bit0=a ... bit6=g
digit_en  out  DIGITS  active-low one-hot digit select; bit0 = least-significant nibble, bit DIGITS-1 = carry digit

Behaviour:
- Reset (sync; dominates all other inputs):
  - sum=0, cout=0, ovf=0, valid=0.
  - scan index=0, prescaler=0.
  - digit_en = all ones except bit0=0.
  - segments = 7'b1000000 (glyph "0").
- Arithmetic:
  - (WIDTH+1)-bit add. sum takes the low WIDTH bits; cout takes bit WIDTH.
  - Wrap-around is modulo 2^WIDTH.
  - Latency 1: sum/cout update on the edge where go=1; valid=1 during the following cycle only.
  - go held high performs one operation per cycle, so accumulate adds every cycle.
- clear=1 (no reset):
  - sum, cout, ovf <= 0; valid <= 0.
  - clear wins over a simultaneous go; that go is dropped.
- ovf:
  - Set when mode=1, go=1 and the carry out is 1.
  - Cleared only by clear or reset. Mode=0 operations neither set nor clear it.
- Scanning:
  - Prescaler counts 0..SCAN_DIV-1. On the wrap, the scan index advances i -> (i+1) mod DIGITS.
  - The index steps 0,1,...,DIGITS-1,0. Each digit is active for exactly SCAN_DIV cycles.
  - digit_en and segments are both registered and change on the same edge. No cycle ever shows one digit's select with another digit's glyph.
- Glyph selection:
  - Index k < DIGITS-1 shows nibble sum[4k+3:4k].
  - Index DIGITS-1 shows {3'b000, cout}, i.e. "0" or "1".
  - Glyph data is taken from the sum/cout registers as they are on the load edge.
- Hex codes (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking (LZB=1 only):
  - Blank = segments 7'b1111111; digit_en is still driven.
  - Nibble digit k>0 is blanked when it and all higher nibbles are zero.
  - Digit 0 is never blanked.
  - The carry digit is blanked when cout=0.
- Operand changes without go have no effect on any output.

Test Plan:
Bench configuration: WIDTH=8, SCAN_DIV=4, LZB=0 unless noted.
- Reset: assert reset 2 cycles while go=1, A=8'hFF -> sum=0, cout=0, ovf=0, valid=0, digit_en=3'b110, segments=1000000.
- Load: A=8'h3C, B=8'h05, cin=1, mode=0, go 1 cycle -> next cycle sum=8'h42, cout=0, valid=1 for exactly 1 cycle; scan shows "2", "4", "0", each for 4 cycles, digit_en sequence 110, 101, 011.
- Wrap/carry: A=8'hF0, B=8'h20, cin=0, mode=0, go -> sum=8'h10, cout=1, ovf=0; carry digit shows 1111001.
- Accumulate: clear, then mode=1, A=8'h80, go held 3 cycles -> sum 80, 00 (cout=1, ovf=1), 80 (cout=0, ovf stays 1).
- Priority: clear and go together with ovf=1 -> sum=0, ovf=0, valid=0 next cycle.
- LZB=1: load sum=8'h05, cout=0 -> digit0 = 0010010; digit1 and carry digit = 1111111. Load 8'h50 -> digit0 = "0" (not blanked), digit1 = "5".
